// File: rtl/popcount_frame_stats.sv
// popcount_frame_stats
//   Groups a stream of 5-bit popcount values into frames of FRAME_LEN words
//   and reports, per frame, the sum, minimum and maximum count, a threshold
//   flag and an input-range error flag.
//
// Parameters
//   FRAME_LEN  words per frame (1..255)
//   THRESH     over_thresh asserts when the frame sum is strictly above this (0..4080)
//
// Ports
//   clk          clock, rising edge
//   reset_n      asynchronous active-low reset
//   cnt_in       popcount value (legal 0..16; larger values are clamped to 16)
//   cnt_valid    cnt_in valid
//   cnt_ready    block accepts cnt_in (registered, 1 only in ACCUM)
//   frame_abort  discards the frame in progress (ignored while a result is held)
//   stat_valid   frame result valid
//   stat_ready   downstream accepts the result
//   sum_out      frame sum
//   min_out      smallest count in the frame
//   max_out      largest count in the frame
//   over_thresh  sum_out > THRESH
//   in_err       some word of the frame had cnt_in > 16
//   state_dbg    current FSM state (0 = ACCUM, 1 = HOLD)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and data stable until the transfer; ready
// never depends combinationally on the partner's valid.

module popcount_frame_stats #(
   parameter int FRAME_LEN = 8,
   parameter int THRESH    = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [4:0]  cnt_in,
   input  logic        cnt_valid,
   output logic        cnt_ready,
   input  logic        frame_abort,
   output logic        stat_valid,
   input  logic        stat_ready,
   output logic [11:0] sum_out,
   output logic [4:0]  min_out,
   output logic [4:0]  max_out,
   output logic        over_thresh,
   output logic        in_err,
   output logic        state_dbg
);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   localparam logic [7:0]  LAST_IDX = 8'(FRAME_LEN - 1);
   localparam logic [11:0] THRESH_W = 12'(THRESH);
   localparam logic [4:0]  CNT_MAX  = 5'd16;

   state_t      state_q, state_d;

   // Running frame state
   logic [11:0] acc_q, acc_d;
   logic [4:0]  run_min_q, run_min_d;
   logic [4:0]  run_max_q, run_max_d;
   logic [7:0]  idx_q, idx_d;
   logic        err_q, err_d;

   // Output registers
   logic        ready_q, ready_d;
   logic        stat_valid_q, stat_valid_d;
   logic [11:0] sum_q, sum_d;
   logic [4:0]  min_q, min_d;
   logic [4:0]  max_q, max_d;
   logic        over_q, over_d;
   logic        in_err_q, in_err_d;

   // Word datapath
   logic        accept;
   logic        word_bad;
   logic [4:0]  word_clamped;
   logic [11:0] new_sum;
   logic [4:0]  new_min;
   logic [4:0]  new_max;
   logic        new_err;

   assign word_bad     = (cnt_in > CNT_MAX);
   assign word_clamped = word_bad ? CNT_MAX : cnt_in;
   assign new_sum      = acc_q + {7'd0, word_clamped};
   assign new_min      = (word_clamped < run_min_q) ? word_clamped : run_min_q;
   assign new_max      = (word_clamped > run_max_q) ? word_clamped : run_max_q;
   assign new_err      = err_q | word_bad;

   // ready_q is high exactly when the FSM is in ACCUM (and out of reset),
   // so it is a safe stand-in for the state in the accept term.
   assign accept = cnt_valid && ready_q;

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      run_min_d    = run_min_q;
      run_max_d    = run_max_q;
      idx_d        = idx_q;
      err_d        = err_q;
      stat_valid_d = stat_valid_q;
      sum_d        = sum_q;
      min_d        = min_q;
      max_d        = max_q;
      over_d       = over_q;
      in_err_d     = in_err_q;

      unique case (state_q)
         ACCUM: begin
            if (frame_abort) begin
               // Abort wins over a coincident accept, even on the last word.
               acc_d     = 12'd0;
               run_min_d = CNT_MAX;
               run_max_d = 5'd0;
               idx_d     = 8'd0;
               err_d     = 1'b0;
            end else if (accept) begin
               if (idx_q == LAST_IDX) begin
                  sum_d        = new_sum;
                  min_d        = new_min;
                  max_d        = new_max;
                  over_d       = (new_sum > THRESH_W);
                  in_err_d     = new_err;
                  stat_valid_d = 1'b1;
                  state_d      = HOLD;
                  acc_d        = 12'd0;
                  run_min_d    = CNT_MAX;
                  run_max_d    = 5'd0;
                  idx_d        = 8'd0;
                  err_d        = 1'b0;
               end else begin
                  acc_d     = new_sum;
                  run_min_d = new_min;
                  run_max_d = new_max;
                  idx_d     = idx_q + 8'd1;
                  err_d     = new_err;
               end
            end
         end
         HOLD: begin
            if (stat_valid_q && stat_ready) begin
               stat_valid_d = 1'b0;
               state_d      = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase

      ready_d = (state_d == ACCUM);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ACCUM;
         acc_q        <= 12'd0;
         run_min_q    <= CNT_MAX;
         run_max_q    <= 5'd0;
         idx_q        <= 8'd0;
         err_q        <= 1'b0;
         ready_q      <= 1'b0;
         stat_valid_q <= 1'b0;
         sum_q        <= 12'd0;
         min_q        <= 5'd0;
         max_q        <= 5'd0;
         over_q       <= 1'b0;
         in_err_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         run_min_q    <= run_min_d;
         run_max_q    <= run_max_d;
         idx_q        <= idx_d;
         err_q        <= err_d;
         ready_q      <= ready_d;
         stat_valid_q <= stat_valid_d;
         sum_q        <= sum_d;
         min_q        <= min_d;
         max_q        <= max_d;
         over_q       <= over_d;
         in_err_q     <= in_err_d;
      end
   end

   assign cnt_ready   = ready_q;
   assign stat_valid  = stat_valid_q;
   assign sum_out     = sum_q;
   assign min_out     = min_q;
   assign max_out     = max_q;
   assign over_thresh = over_q;
   assign in_err      = in_err_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_popcount_frame_stats.sv
// Testbench for popcount_frame_stats. Four instances share the input stimulus:
//   d=0: FRAME_LEN=4, THRESH=20   d=1: FRAME_LEN=4, THRESH=64
//   d=2: FRAME_LEN=2, THRESH=64   d=3: FRAME_LEN=1, THRESH=64
// Every scenario starts from reset, so the instances not under test are harmless.

module tb_popcount_frame_stats;

   logic       clk;
   logic       reset_n;
   logic [4:0] cnt_in;
   logic       cnt_valid;
   logic       frame_abort;
   logic       stat_ready;

   logic        cnt_ready_a  [4];
   logic        stat_valid_a [4];
   logic [11:0] sum_a        [4];
   logic [4:0]  min_a        [4];
   logic [4:0]  max_a        [4];
   logic        over_a       [4];
   logic        err_a        [4];
   logic        state_a      [4];

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   popcount_frame_stats #(.FRAME_LEN(4), .THRESH(20)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .cnt_in(cnt_in), .cnt_valid(cnt_valid),
      .cnt_ready(cnt_ready_a[0]), .frame_abort(frame_abort),
      .stat_valid(stat_valid_a[0]), .stat_ready(stat_ready), .sum_out(sum_a[0]),
      .min_out(min_a[0]), .max_out(max_a[0]), .over_thresh(over_a[0]),
      .in_err(err_a[0]), .state_dbg(state_a[0]));

   popcount_frame_stats #(.FRAME_LEN(4), .THRESH(64)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .cnt_in(cnt_in), .cnt_valid(cnt_valid),
      .cnt_ready(cnt_ready_a[1]), .frame_abort(frame_abort),
      .stat_valid(stat_valid_a[1]), .stat_ready(stat_ready), .sum_out(sum_a[1]),
      .min_out(min_a[1]), .max_out(max_a[1]), .over_thresh(over_a[1]),
      .in_err(err_a[1]), .state_dbg(state_a[1]));

   popcount_frame_stats #(.FRAME_LEN(2), .THRESH(64)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .cnt_in(cnt_in), .cnt_valid(cnt_valid),
      .cnt_ready(cnt_ready_a[2]), .frame_abort(frame_abort),
      .stat_valid(stat_valid_a[2]), .stat_ready(stat_ready), .sum_out(sum_a[2]),
      .min_out(min_a[2]), .max_out(max_a[2]), .over_thresh(over_a[2]),
      .in_err(err_a[2]), .state_dbg(state_a[2]));

   popcount_frame_stats #(.FRAME_LEN(1), .THRESH(64)) u_dut3 (
      .clk(clk), .reset_n(reset_n), .cnt_in(cnt_in), .cnt_valid(cnt_valid),
      .cnt_ready(cnt_ready_a[3]), .frame_abort(frame_abort),
      .stat_valid(stat_valid_a[3]), .stat_ready(stat_ready), .sum_out(sum_a[3]),
      .min_out(min_a[3]), .max_out(max_a[3]), .over_thresh(over_a[3]),
      .in_err(err_a[3]), .state_dbg(state_a[3]));

   // Driver tasks: inputs change 1 time unit after a rising edge, outputs are
   // sampled at the same point, i.e. they reflect the edge just passed.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n     = 1'b0;
      cnt_valid   = 1'b0;
      cnt_in      = 5'd0;
      frame_abort = 1'b0;
      stat_ready  = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic send_word(input logic [4:0] v);
      cnt_valid = 1'b1;
      cnt_in    = v;
      step();
      cnt_valid = 1'b0;
   endtask

   task automatic handshake();
      stat_ready = 1'b1;
      step();
      stat_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset_n     = 1'b0;
      cnt_valid   = 1'b0;
      cnt_in      = 5'd0;
      frame_abort = 1'b0;
      stat_ready  = 1'b0;
      step();
      step();
      total_cnt++;
      if (cnt_ready_a[0] !== 1'b0) $display("FAIL reset_cnt_ready: got %0b want 0", cnt_ready_a[0]);
      else pass_cnt++;
      total_cnt++;
      if (stat_valid_a[0] !== 1'b0) $display("FAIL reset_stat_valid: got %0b want 0", stat_valid_a[0]);
      else pass_cnt++;
      total_cnt++;
      if ({sum_a[0], min_a[0], max_a[0], over_a[0], err_a[0]} !== 24'd0)
         $display("FAIL reset_outputs: got sum=%0d min=%0d max=%0d over=%0b err=%0b want all 0",
                  sum_a[0], min_a[0], max_a[0], over_a[0], err_a[0]);
      else pass_cnt++;
      reset_n = 1'b1;
      step();
      total_cnt++;
      if (cnt_ready_a[0] !== 1'b1) $display("FAIL release_cnt_ready: got %0b want 1", cnt_ready_a[0]);
      else pass_cnt++;
   endtask

   // Basic frame followed by 5 cycles of backpressure and the handshake.
   task automatic test_basic_backpressure();
      do_reset();
      send_word(5'd3);
      send_word(5'd16);
      send_word(5'd0);
      total_cnt++;
      if (stat_valid_a[0] !== 1'b0) $display("FAIL basic_early_valid: got %0b want 0", stat_valid_a[0]);
      else pass_cnt++;
      send_word(5'd7);
      total_cnt++;
      if (stat_valid_a[0] !== 1'b1 || sum_a[0] !== 12'd26 || min_a[0] !== 5'd0 ||
          max_a[0] !== 5'd16 || over_a[0] !== 1'b1 || err_a[0] !== 1'b0)
         $display("FAIL basic_result: got v=%0b sum=%0d min=%0d max=%0d over=%0b err=%0b want v=1 sum=26 min=0 max=16 over=1 err=0",
                  stat_valid_a[0], sum_a[0], min_a[0], max_a[0], over_a[0], err_a[0]);
      else pass_cnt++;
      cnt_valid = 1'b1;
      cnt_in    = 5'd9;
      for (int i = 0; i < 5; i++) begin
         total_cnt++;
         if (stat_valid_a[0] !== 1'b1 || cnt_ready_a[0] !== 1'b0 || sum_a[0] !== 12'd26 ||
             min_a[0] !== 5'd0 || max_a[0] !== 5'd16 || over_a[0] !== 1'b1)
            $display("FAIL backpressure_hold[%0d]: got v=%0b rdy=%0b sum=%0d min=%0d max=%0d over=%0b want v=1 rdy=0 sum=26 min=0 max=16 over=1",
                     i, stat_valid_a[0], cnt_ready_a[0], sum_a[0], min_a[0], max_a[0], over_a[0]);
         else pass_cnt++;
         step();
      end
      cnt_valid = 1'b0;
      handshake();
      total_cnt++;
      if (stat_valid_a[0] !== 1'b0 || cnt_ready_a[0] !== 1'b1)
         $display("FAIL handshake_release: got v=%0b rdy=%0b want v=0 rdy=1", stat_valid_a[0], cnt_ready_a[0]);
      else pass_cnt++;
      total_cnt++;
      if (sum_a[0] !== 12'd26 || max_a[0] !== 5'd16)
         $display("FAIL held_after_handshake: got sum=%0d max=%0d want sum=26 max=16", sum_a[0], max_a[0]);
      else pass_cnt++;
   endtask

   task automatic test_abort();
      do_reset();
      send_word(5'd5);
      send_word(5'd5);
      frame_abort = 1'b1;
      send_word(5'd9);
      frame_abort = 1'b0;
      send_word(5'd1);
      send_word(5'd2);
      send_word(5'd3);
      total_cnt++;
      if (stat_valid_a[0] !== 1'b0) $display("FAIL abort_early_valid: got %0b want 0", stat_valid_a[0]);
      else pass_cnt++;
      send_word(5'd4);
      total_cnt++;
      if (stat_valid_a[0] !== 1'b1 || sum_a[0] !== 12'd10 || min_a[0] !== 5'd1 ||
          max_a[0] !== 5'd4 || over_a[0] !== 1'b0)
         $display("FAIL abort_result: got v=%0b sum=%0d min=%0d max=%0d over=%0b want v=1 sum=10 min=1 max=4 over=0",
                  stat_valid_a[0], sum_a[0], min_a[0], max_a[0], over_a[0]);
      else pass_cnt++;
      // Abort while holding a result is ignored.
      frame_abort = 1'b1;
      step();
      frame_abort = 1'b0;
      total_cnt++;
      if (stat_valid_a[0] !== 1'b1 || sum_a[0] !== 12'd10)
         $display("FAIL abort_in_hold: got v=%0b sum=%0d want v=1 sum=10", stat_valid_a[0], sum_a[0]);
      else pass_cnt++;
      handshake();
   endtask

   task automatic test_clamp();
      do_reset();
      send_word(5'd20);
      send_word(5'd2);
      total_cnt++;
      if (stat_valid_a[2] !== 1'b1 || sum_a[2] !== 12'd18 || min_a[2] !== 5'd2 ||
          max_a[2] !== 5'd16 || err_a[2] !== 1'b1 || over_a[2] !== 1'b0)
         $display("FAIL clamp_result: got v=%0b sum=%0d min=%0d max=%0d err=%0b over=%0b want v=1 sum=18 min=2 max=16 err=1 over=0",
                  stat_valid_a[2], sum_a[2], min_a[2], max_a[2], err_a[2], over_a[2]);
      else pass_cnt++;
      handshake();
      send_word(5'd1);
      send_word(5'd1);
      total_cnt++;
      if (stat_valid_a[2] !== 1'b1 || sum_a[2] !== 12'd2 || min_a[2] !== 5'd1 ||
          max_a[2] !== 5'd1 || err_a[2] !== 1'b0)
         $display("FAIL clamp_next_frame: got v=%0b sum=%0d min=%0d max=%0d err=%0b want v=1 sum=2 min=1 max=1 err=0",
                  stat_valid_a[2], sum_a[2], min_a[2], max_a[2], err_a[2]);
      else pass_cnt++;
      handshake();
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      send_word(5'd1);
      send_word(5'd2);
      send_word(5'd3);
      reset_n = 1'b0;
      #2;
      total_cnt++;
      if (cnt_ready_a[1] !== 1'b0 || stat_valid_a[1] !== 1'b0 ||
          {sum_a[1], min_a[1], max_a[1], over_a[1], err_a[1]} !== 24'd0)
         $display("FAIL midreset_outputs: got rdy=%0b v=%0b sum=%0d min=%0d max=%0d want all 0",
                  cnt_ready_a[1], stat_valid_a[1], sum_a[1], min_a[1], max_a[1]);
      else pass_cnt++;
      step();
      reset_n = 1'b1;
      step();
      send_word(5'd16);
      send_word(5'd16);
      send_word(5'd16);
      total_cnt++;
      if (stat_valid_a[1] !== 1'b0) $display("FAIL midreset_early_valid: got %0b want 0", stat_valid_a[1]);
      else pass_cnt++;
      send_word(5'd16);
      total_cnt++;
      if (stat_valid_a[1] !== 1'b1 || sum_a[1] !== 12'd64 || over_a[1] !== 1'b0 ||
          min_a[1] !== 5'd16 || max_a[1] !== 5'd16)
         $display("FAIL midreset_result: got v=%0b sum=%0d over=%0b min=%0d max=%0d want v=1 sum=64 over=0 min=16 max=16",
                  stat_valid_a[1], sum_a[1], over_a[1], min_a[1], max_a[1]);
      else pass_cnt++;
      handshake();
   endtask

   task automatic test_frame_len1();
      do_reset();
      stat_ready = 1'b1;
      cnt_valid  = 1'b1;
      cnt_in     = 5'd0;
      step();
      cnt_in = 5'd16;
      total_cnt++;
      if (stat_valid_a[3] !== 1'b1 || cnt_ready_a[3] !== 1'b0 || sum_a[3] !== 12'd0 ||
          min_a[3] !== 5'd0 || max_a[3] !== 5'd0)
         $display("FAIL len1_first: got v=%0b rdy=%0b sum=%0d min=%0d max=%0d want v=1 rdy=0 sum=0 min=0 max=0",
                  stat_valid_a[3], cnt_ready_a[3], sum_a[3], min_a[3], max_a[3]);
      else pass_cnt++;
      step();
      total_cnt++;
      if (stat_valid_a[3] !== 1'b0 || cnt_ready_a[3] !== 1'b1)
         $display("FAIL len1_gap: got v=%0b rdy=%0b want v=0 rdy=1", stat_valid_a[3], cnt_ready_a[3]);
      else pass_cnt++;
      step();
      cnt_valid = 1'b0;
      total_cnt++;
      if (stat_valid_a[3] !== 1'b1 || sum_a[3] !== 12'd16 || min_a[3] !== 5'd16 || max_a[3] !== 5'd16)
         $display("FAIL len1_second: got v=%0b sum=%0d min=%0d max=%0d want v=1 sum=16 min=16 max=16",
                  stat_valid_a[3], sum_a[3], min_a[3], max_a[3]);
      else pass_cnt++;
      step();
      stat_ready = 1'b0;
      total_cnt++;
      if (stat_valid_a[3] !== 1'b0)
         $display("FAIL len1_done: got v=%0b want 0 (no extra frame)", stat_valid_a[3]);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic_backpressure();
      test_abort();
      test_clamp();
      test_reset_mid_frame();
      test_frame_len1();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
